rca_word_sequencer: RTL and testbench
=====================================

// Module: rca_word_sequencer
// PURPOSE
//  Multi-cycle wide-word adder controller. Reuses one CHUNK-bit ripple-carry
//  adder slice over NCHUNK cycles, LSB chunk first, with a carry register
//  between chunks. Sits between an operand producer and a result consumer,
//  each side with a valid/ready handshake. Trades latency for adder area.
// PARAMETERS
//  CHUNK   3  width of the shared ripple-carry slice, in bits (>=1)
//  NCHUNK  4  chunks per word (>=2); W = CHUNK*NCHUNK (W=12 by default)
// PORTS
//  clk        in   1  single clock; all state updates on its rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operands a/b/cin are valid
//  in_ready   out  1  block can accept operands
//  a          in   W  operand A, unsigned or two's complement
//  b          in   W  operand B
//  cin        in   1  carry-in to the LSB chunk
//  out_valid  out  1  sum/cout/ovf are valid
//  out_ready  in   1  consumer accepts the result
//  sum        out  W  a+b+cin, modulo 2^W
//  cout       out  1  carry out of bit W-1
//  ovf        out  1  signed overflow: carry into bit W-1 XOR cout
//  busy       out  1  high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE, chunk index=0, carry reg=0, sum=0, cout=0, ovf=0,
//   out_valid=0, busy=0. in_ready = (state==IDLE) & !rst, so it is 0 during
//   the reset cycle.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready=1. On in_valid&in_ready (cycle T), latch a, b, cin into
//   operand regs. Set index=0 and carry reg=cin. Go to RUN. No other action.
//  RUN: in_ready=0. Each cycle, chunk k=index is added:
//   {c,s} = a[k*CHUNK+:CHUNK] + b[k*CHUNK+:CHUNK] + carry.
//   s is written to sum[k*CHUNK+:CHUNK], and carry <= c.
//   The carry into the chunk MSB is also computed and kept for ovf.
//   index increments by 1. When index==NCHUNK-1, write cout=c and ovf, then
//   go to DONE. RUN lasts exactly NCHUNK cycles (T+1..T+NCHUNK).
//  DONE: out_valid=1 from cycle T+NCHUNK+1. Latency from accept to out_valid
//   is NCHUNK+1 cycles. sum, cout and ovf hold stable while out_valid=1 and
//   out_ready=0, for any number of cycles.
//   On out_valid&out_ready: go to IDLE, out_valid=0 the next cycle.
//   sum, cout and ovf keep their last values until overwritten by RUN.
//  Minimum issue interval: NCHUNK+2 cycles. No accept is possible in DONE,
//   even with out_ready=1.
//  in_valid while in_ready=0 is ignored. It is neither queued nor an error.
//   Operand inputs may change freely after the accept cycle.
//  Partial sum bits in RUN are not valid; consumers sample only on out_valid.
//  Wrap-around: the result is modulo 2^W. The carry ripples across chunk
//   boundaries only through the carry reg, one chunk per cycle.
//  rst=1 in any state, including mid-RUN or DONE with out_ready=0, takes
//   priority. The in-flight operation is discarded with no result emitted.
//   All reset values apply the next cycle.
//  busy = (state != IDLE).
// TESTING (CHUNK=3, NCHUNK=4, W=12)
//  1. a=0x005, b=0x003, cin=0, accept at T -> out_valid rises at T+5;
//     sum=0x008, cout=0, ovf=0.
//  2. a=0xFFF, b=0x001, cin=0 -> sum=0x000, cout=1, ovf=0
//     (carry crosses all 4 chunk boundaries).
//  3. a=0x7FF, b=0x001, cin=0 -> sum=0x800, cout=0, ovf=1. Then a=0xFFF,
//     b=0xFFF, cin=1 -> sum=0xFFF, cout=1, ovf=0.
//  4. Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid ->
//     sum/cout/ovf constant, in_ready=0, no second accept. After out_ready=1,
//     IDLE on the next cycle.
//  5. Assert rst at T+2 (mid-RUN) -> next cycle state=IDLE, out_valid=0,
//     sum=0, busy=0, in_ready=1 once rst=0. No out_valid pulse follows.
//  6. Random a/b/cin, back-to-back with in_valid and out_ready tied high ->
//     every result equals a+b+cin. Accepts are exactly NCHUNK+2=6 cycles apart.

Source files
------------

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: multi-cycle wide-word adder reusing one CHUNK-bit
// ripple-carry slice over NCHUNK cycles, LSB chunk first.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   busy                high while an operation is in RUN or DONE
module rca_word_sequencer #(
  parameter int CHUNK  = 3,
  parameter int NCHUNK = 4,
  parameter int W      = CHUNK * NCHUNK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [CHUNK-1:0] op_a;
  logic [CHUNK-1:0] op_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_c;
  logic             slice_cmsb;
  logic             rc;

  assign op_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign op_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

  // The shared slice. slice_cmsb is the carry into the slice MSB; on the
  // last chunk that is the carry into bit W-1, which ovf needs.
  always_comb begin
    slice_s    = '0;
    slice_cmsb = 1'b0;
    rc         = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) slice_cmsb = rc;
      slice_s[i] = op_a[i] ^ op_b[i] ^ rc;
      rc = (op_a[i] & op_b[i]) | (rc & (op_a[i] ^ op_b[i]));
    end
    slice_c = rc;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_s;
        carry_d = slice_c;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = slice_c;
          ovf_d   = slice_c ^ slice_cmsb;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb_rca_word_sequencer: directed checks of the chunked adder sequencer
// plus a back-to-back streaming run with an expected-result queue.
module tb_rca_word_sequencer;

  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rca_word_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [13:0] model(input logic [11:0] x,
                                        input logic [11:0] y,
                                        input logic c);
    logic [12:0] t;
    logic v;
    t = {1'b0, x} + {1'b0, y} + {12'd0, c};
    v = (x[11] == y[11]) && (t[11] != x[11]);
    return {v, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, measure latency, check result, then drain it.
  task automatic do_op(input logic [11:0] xa, input logic [11:0] xb,
                       input logic xc, input logic [11:0] esum,
                       input logic ec, input logic ev);
    int lat;
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1; a = xa; b = xb; cin = xc;
    tick();
    in_valid = 0; a = '1; b = '1; cin = 1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, 5);
    chk("sum", sum, esum);
    chk("cout", cout, ec);
    chk("ovf", ovf, ev);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("drain_valid", out_valid, 0);
    chk("drain_busy", busy, 0);
  endtask

  // Streaming monitor: samples on the falling edge, away from updates.
  bit          mon_en = 0;
  logic [13:0] expq[$];
  int          cyc = 0;
  int          last_acc = -1;
  int          n_acc = 0;
  int          n_res = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin));
        if (last_acc >= 0) chk("issue_gap", cyc - last_acc, 6);
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_result", 1, 0);
        else chk("stream_res", {ovf, cout, sum}, expq.pop_front());
        n_res++;
      end
    end
  end

  initial begin
    logic [11:0] s0;
    logic        c0, v0;
    int guard;
    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 0;
    #1;

    do_op(12'h005, 12'h003, 0, 12'h008, 0, 0);
    do_op(12'hFFF, 12'h001, 0, 12'h000, 1, 0);
    do_op(12'h7FF, 12'h001, 0, 12'h800, 0, 1);
    do_op(12'hFFF, 12'hFFF, 1, 12'hFFF, 1, 0);

    // Hold the result in DONE while in_valid toggles.
    in_valid = 1; a = 12'h123; b = 12'h456; cin = 1;
    tick();
    a = 12'h0AA; b = 12'h055;
    for (int i = 0; i < 4; i++) tick();
    chk("hold_enter", out_valid, 1);
    s0 = sum; c0 = cout; v0 = ovf;
    chk("hold_sum0", s0, 12'h57A);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", sum, 12'h57A);
      chk("hold_cout", cout, 0);
      chk("hold_ovf", ovf, 0);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("hold_release_busy", busy, 0);
    chk("hold_release_ready", in_ready, 1);
    chk("hold_keep_sum", sum, 12'h57A);

    // Reset in the middle of RUN discards the operation.
    in_valid = 1; a = 12'h321; b = 12'h111; cin = 0;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("midrst_ready_after", in_ready, 1);
    begin
      int seen = 0;
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid) seen++;
      end
      out_ready = 0;
      chk("midrst_no_result", seen, 0);
    end

    // Back-to-back random stream.
    out_ready = 1;
    in_valid = 1;
    mon_en = 1;
    guard = 0;
    while (n_acc < 8 && guard < 200) begin
      a = 12'($urandom); b = 12'($urandom); cin = 1'($urandom);
      tick();
      guard++;
    end
    in_valid = 0;
    guard = 0;
    while (expq.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("stream_accepts", n_acc, 8);
    chk("stream_results", n_res, 8);
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
